// File: rtl/pdu_tx_parser_pkg.sv
// Shared types and constants for the PDU TX parser and its RX counterpart.
// The descriptor layout matches the PCIe-side TX descriptor FIFO word.
package pdu_tx_parser_pkg;

  localparam int APP_IDX_WIDTH = 8;
  localparam int FLIT_BYTES    = 64;
  localparam int FLIT_BITS     = FLIT_BYTES * 8;

  typedef struct packed {
    logic [APP_IDX_WIDTH-1:0] queue_id;
    logic [15:0]              size_bytes;
  } tx_desc_t;

  // Unused bytes in the final flit; a whole number of flits leaves none.
  function automatic logic [5:0] eop_empty(input logic [15:0] size_bytes);
    return 6'(7'd64 - {1'b0, size_bytes[5:0]});
  endfunction

endpackage

// File: rtl/pdu_tx_parser_byte_swap.sv
// Reverses the byte order of a 512-bit flit (PCIe order <-> MAC order).
// The mapping is its own inverse, so the RX generator can reuse it as is.
module byte_swap_512
  import pdu_tx_parser_pkg::*;
(
  input  logic [FLIT_BITS-1:0] data,
  output logic [FLIT_BITS-1:0] swapped
);

  for (genvar i = 0; i < FLIT_BYTES; i++) begin : g_byte
    assign swapped[FLIT_BITS-1-8*i -: 8] = data[8*i +: 8];
  end

endmodule

// File: rtl/pdu_tx_parser.sv
// Pops TX descriptors and their flits from the PCIe TX FIFOs and emits a
// byte-reordered Avalon-ST packet stream toward the MAC TX adapter.
module pdu_tx_parser
  import pdu_tx_parser_pkg::*;
#(
  parameter int MAX_PKT_BYTES = 9600,
  parameter int FLIT_BYTES    = pdu_tx_parser_pkg::FLIT_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     desc_valid,
  input  tx_desc_t                 desc_data,
  output logic                     desc_ready,
  input  logic                     flit_valid,
  input  logic [511:0]             flit_data,
  output logic                     flit_ready,
  output logic [511:0]             out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [5:0]               out_empty,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [APP_IDX_WIDTH-1:0] out_queue_id,
  output logic [31:0]              pkt_cnt,
  output logic [31:0]              drop_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]               state;
  logic [APP_IDX_WIDTH-1:0] queue_id_q;
  logic [7:0]               flits_left;
  logic [5:0]               last_empty;
  logic                     first;

  logic [31:0]  size_ext;
  logic         size_ok;
  logic         can_load;
  logic         last_flit;
  logic [511:0] swapped;

  assign size_ext  = 32'(desc_data.size_bytes);
  assign size_ok   = (size_ext != 32'd0) && (size_ext <= 32'(MAX_PKT_BYTES));
  assign can_load  = !out_valid || out_ready;
  assign last_flit = (flits_left == 8'd1);

  assign desc_ready = (state == ST_IDLE) && desc_valid;
  assign flit_ready = (state == ST_DATA) && flit_valid && can_load;

  byte_swap_512 u_swap (
    .data    (flit_data),
    .swapped (swapped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      queue_id_q <= '0;
      flits_left <= '0;
      last_empty <= '0;
      first      <= 1'b0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (desc_ready) begin
            // Illegal lengths are consumed without touching the flit FIFO.
            if (size_ok) begin
              queue_id_q <= desc_data.queue_id;
              flits_left <= 8'((size_ext + 32'(FLIT_BYTES) - 32'd1) / 32'(FLIT_BYTES));
              last_empty <= eop_empty(desc_data.size_bytes);
              first      <= 1'b1;
              state      <= ST_DATA;
            end else begin
              drop_cnt <= drop_cnt + 32'd1;
            end
          end
        end
        ST_DATA: begin
          if (flit_ready) begin
            first      <= 1'b0;
            flits_left <= flits_left - 8'd1;
            if (last_flit) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: loads on every flit pop, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_empty    <= '0;
      out_queue_id <= '0;
    end else if (flit_ready) begin
      out_valid    <= 1'b1;
      out_sop      <= first;
      out_eop      <= last_flit;
      out_empty    <= last_flit ? last_empty : 6'd0;
      out_queue_id <= queue_id_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (flit_ready) begin
      out_data <= swapped;
    end
  end

endmodule
